// File: rtl/tlul_pkg.sv
// Minimal TileLink-UL channel types shared by crossbar-facing blocks.
// Covers only the A/D fields this SRAM responder needs (32-bit data bus).
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    localparam logic [15:0] TL_D_USER_DEFAULT = 16'h0000;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_pkg.sv
// Response-entry type and request legality helpers for the TL-UL SRAM responder.
// Error detection is purely combinational on the A channel.
package tlul_sram_pkg;
    import tlul_pkg::*;

    typedef struct packed {
        tl_d_op_e    opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic        error;
        logic [31:0] data;
    } rsp_entry_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << addr_lo;
            2'd1:    m = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic is_put(input tl_a_op_e op);
        return (op == PutFullData) || (op == PutPartialData);
    endfunction

    function automatic logic req_error(input tl_h2d_t req);
        logic bad_op;
        logic bad_size;
        logic misaligned;
        logic bad_full_mask;
        logic empty_mask;
        bad_op        = !(is_put(req.a_opcode) || (req.a_opcode == Get));
        bad_size      = (req.a_size > 2'd2);
        misaligned    = ((req.a_size == 2'd1) && req.a_address[0]) ||
                        ((req.a_size == 2'd2) && (req.a_address[1:0] != 2'b00));
        bad_full_mask = (req.a_opcode == PutFullData) &&
                        (req.a_mask != lane_mask(req.a_size, req.a_address[1:0]));
        empty_mask    = is_put(req.a_opcode) && (req.a_mask == 4'h0);
        return bad_op || bad_size || misaligned || bad_full_mask || empty_mask;
    endfunction

endpackage

// File: rtl/tlul_rsp_fifo.sv
// Circular response buffer with occupancy count; push while full and pop
// while empty are ignored so the caller only has to gate on its own credit.
module tlul_rsp_fifo #(
    parameter int  DEPTH = 3,
    parameter type T     = logic,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  T                 wdata_i,
    input  logic             pop_i,
    output T                 rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && !empty_o;
        wptr_d  = push_ok ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop_ok ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wptr_q] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through a valid count.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tlul_sram_responder.sv
// TL-UL device adapter for a single-port SRAM with 1-cycle read latency.
// A fire -> pend stage (waits for read data) -> response FIFO -> D channel.
module tlul_sram_responder
    import tlul_pkg::*;
    import tlul_sram_pkg::*;
#(
    parameter int SRAM_AW   = 14,
    parameter int RSP_DEPTH = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  tl_h2d_t            tl_i,
    output tl_d2h_t            tl_o,
    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_wdata_o,
    output logic [31:0]        sram_wmask_o,
    input  logic [31:0]        sram_rdata_i
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic             a_ready;
    logic             a_fire;
    logic             a_err;
    logic             a_put;
    logic [OCC_W-1:0] occupancy;

    logic             pend_valid_q, pend_valid_d;
    rsp_entry_t       pend_q, pend_d;

    rsp_entry_t       fifo_wdata;
    rsp_entry_t       fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             d_valid;
    logic             unused_pend_data;

    // Credit counts the pend stage too, so a_ready never looks at d_ready.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(pend_valid_q);
    assign a_ready   = !rst_i && !fifo_full && (occupancy < OCC_W'(RSP_DEPTH));
    assign a_fire    = tl_i.a_valid && a_ready;
    assign a_err     = req_error(tl_i);
    assign a_put     = is_put(tl_i.a_opcode);

    assign sram_req_o   = a_fire && !a_err;
    assign sram_we_o    = sram_req_o && a_put;
    assign sram_addr_o  = sram_req_o ? tl_i.a_address[SRAM_AW+1:2] : '0;
    assign sram_wdata_o = sram_we_o ? tl_i.a_data : '0;
    assign sram_wmask_o = sram_we_o ? {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                                       {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}} : '0;

    always_comb begin
        pend_valid_d = a_fire;
        pend_d       = pend_q;
        if (a_fire) begin
            pend_d.opcode = (tl_i.a_opcode == Get) ? AccessAckData : AccessAck;
            pend_d.size   = tl_i.a_size;
            pend_d.source = tl_i.a_source;
            pend_d.error  = a_err;
            pend_d.data   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
        end
    end

    always_comb begin
        fifo_wdata      = pend_q;
        fifo_wdata.data = (!pend_q.error && (pend_q.opcode == AccessAckData)) ? sram_rdata_i : '0;
    end

    assign unused_pend_data = ^pend_q.data;

    tlul_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (rsp_entry_t)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pend_valid_q),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign d_valid  = !rst_i && !fifo_empty;
    assign fifo_pop = d_valid && tl_i.d_ready;

    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        tl_o.d_user  = TL_D_USER_DEFAULT;
        if (d_valid) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = fifo_rdata.opcode;
            tl_o.d_size   = fifo_rdata.size;
            tl_o.d_source = fifo_rdata.source;
            tl_o.d_data   = fifo_rdata.data;
            tl_o.d_error  = fifo_rdata.error;
        end
    end

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Directed bench for tlul_sram_responder: single-request vector table plus
// backpressure, streaming and mid-flight reset sequences.
module tb_tlul_sram_responder;
    import tlul_pkg::*;

    localparam logic [2:0] OP_PF  = 3'h0;
    localparam logic [2:0] OP_PP  = 3'h1;
    localparam logic [2:0] OP_GET = 3'h4;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [7:0]  src;
        logic        e_req;
        logic        e_we;
        logic [13:0] e_addr;
        logic [31:0] e_wmask;
        logic [2:0]  e_dop;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic        sram_req;
    logic        sram_we;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_wmask;
    logic [31:0] sram_rdata;
    logic [31:0] mem [16];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tlul_sram_responder #(
        .SRAM_AW   (14),
        .RSP_DEPTH (3)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .tl_i         (tl_i),
        .tl_o         (tl_o),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_wmask_o (sram_wmask),
        .sram_rdata_i (sram_rdata)
    );

    // Single-port SRAM stand-in with one cycle of read latency.
    always @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            sram_rdata <= '0;
        end else if (sram_req) begin
            if (sram_we)
                mem[sram_addr[3:0]] <= (mem[sram_addr[3:0]] & ~sram_wmask) | (sram_wdata & sram_wmask);
            else
                sram_rdata <= mem[sram_addr[3:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                           input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = tl_a_op_e'(op);
        tl_i.a_address = addr;
        tl_i.a_size    = size;
        tl_i.a_mask    = mask;
        tl_i.a_data    = data;
        tl_i.a_source  = src;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        @(negedge clk);
        set_req(v.op, v.addr, v.size, v.mask, v.data, v.src);
        #1;
        check($sformatf("v%0d_a_ready", idx), 32'(tl_o.a_ready), 32'd1);
        check($sformatf("v%0d_sram_req", idx), 32'(sram_req), 32'(v.e_req));
        check($sformatf("v%0d_sram_we", idx), 32'(sram_we), 32'(v.e_we));
        check($sformatf("v%0d_sram_addr", idx), 32'(sram_addr), 32'(v.e_addr));
        check($sformatf("v%0d_sram_wmask", idx), sram_wmask, v.e_wmask);
        @(negedge clk);
        tl_i.a_valid = 1'b0;
        #1;
        check($sformatf("v%0d_d_valid_n1", idx), 32'(tl_o.d_valid), 32'd0);
        @(negedge clk);
        #1;
        check($sformatf("v%0d_d_valid_n2", idx), 32'(tl_o.d_valid), 32'd1);
        check($sformatf("v%0d_d_opcode", idx), 32'(tl_o.d_opcode), 32'(v.e_dop));
        check($sformatf("v%0d_d_data", idx), tl_o.d_data, v.e_data);
        check($sformatf("v%0d_d_error", idx), 32'(tl_o.d_error), 32'(v.e_err));
        check($sformatf("v%0d_d_source", idx), 32'(tl_o.d_source), 32'(v.src));
    endtask

    vec_t        vecs [13];
    logic [31:0] bp_addr [3];
    logic [31:0] bp_data [3];
    logic [31:0] st_data [2];
    int          accepted;

    initial begin
        vecs[0]  = '{OP_PF,  32'h0000_0010, 2'd2, 4'hF, 32'hDEAD_BEEF, 8'd1,  1'b1, 1'b1, 14'd4, 32'hFFFF_FFFF, 3'd0, 32'h0,          1'b0};
        vecs[1]  = '{OP_GET, 32'h0000_0010, 2'd2, 4'hF, 32'h0,         8'd5,  1'b1, 1'b0, 14'd4, 32'h0,         3'd1, 32'hDEAD_BEEF,  1'b0};
        vecs[2]  = '{OP_PP,  32'h0000_0006, 2'd1, 4'hC, 32'hABCD_0000, 8'd2,  1'b1, 1'b1, 14'd1, 32'hFFFF_0000, 3'd0, 32'h0,          1'b0};
        vecs[3]  = '{OP_GET, 32'h0000_0004, 2'd2, 4'hF, 32'h0,         8'd3,  1'b1, 1'b0, 14'd1, 32'h0,         3'd1, 32'hABCD_0000,  1'b0};
        vecs[4]  = '{OP_GET, 32'h0000_0002, 2'd2, 4'hF, 32'h0,         8'd4,  1'b0, 1'b0, 14'd0, 32'h0,         3'd1, 32'h0,          1'b1};
        vecs[5]  = '{OP_PF,  32'h0000_0008, 2'd2, 4'h7, 32'h1111_1111, 8'd6,  1'b0, 1'b0, 14'd0, 32'h0,         3'd0, 32'h0,          1'b1};
        vecs[6]  = '{3'h3,   32'h0000_0000, 2'd2, 4'hF, 32'h0,         8'd7,  1'b0, 1'b0, 14'd0, 32'h0,         3'd0, 32'h0,          1'b1};
        vecs[7]  = '{OP_GET, 32'h0000_0000, 2'd3, 4'hF, 32'h0,         8'd8,  1'b0, 1'b0, 14'd0, 32'h0,         3'd1, 32'h0,          1'b1};
        vecs[8]  = '{OP_PP,  32'h0000_0008, 2'd2, 4'h0, 32'h2222_2222, 8'd9,  1'b0, 1'b0, 14'd0, 32'h0,         3'd0, 32'h0,          1'b1};
        vecs[9]  = '{OP_PF,  32'h0000_0001, 2'd0, 4'h2, 32'h0000_5500, 8'd10, 1'b1, 1'b1, 14'd0, 32'h0000_FF00, 3'd0, 32'h0,          1'b0};
        vecs[10] = '{OP_GET, 32'h0000_0002, 2'd1, 4'hC, 32'h0,         8'd11, 1'b1, 1'b0, 14'd0, 32'h0,         3'd1, 32'h0000_5500,  1'b0};
        vecs[11] = '{OP_GET, 32'h1234_0010, 2'd2, 4'hF, 32'h0,         8'd12, 1'b1, 1'b0, 14'd4, 32'h0,         3'd1, 32'hDEAD_BEEF,  1'b0};
        vecs[12] = '{OP_GET, 32'h0000_0001, 2'd1, 4'h3, 32'h0,         8'd13, 1'b0, 1'b0, 14'd0, 32'h0,         3'd1, 32'h0,          1'b1};

        bp_addr = '{32'h0, 32'h4, 32'h10};
        bp_data = '{32'h0000_5500, 32'hABCD_0000, 32'hDEAD_BEEF};
        st_data = '{32'hDEAD_BEEF, 32'hABCD_0000};

        // Reset holds everything quiet even with a request presented.
        rst_i = 1'b1;
        tl_i  = '0;
        set_req(OP_GET, 32'h10, 2'd2, 4'hF, 32'h0, 8'd0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_ready", 32'(tl_o.a_ready), 32'd0);
        check("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
        check("rst_sram_req", 32'(sram_req), 32'd0);
        @(negedge clk);
        rst_i        = 1'b0;
        tl_i.a_valid = 1'b0;
        tl_i.d_ready = 1'b1;
        #1;
        check("post_rst_a_ready", 32'(tl_o.a_ready), 32'd1);

        for (int i = 0; i < 13; i++) apply_vec(i, vecs[i]);

        // Backpressure: only three requests fit, head held stable while stalled.
        @(negedge clk);
        tl_i.d_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (accepted < 3)
                set_req(OP_GET, bp_addr[accepted], 2'd2, 4'hF, 32'h0, 8'(21 + accepted));
            else
                set_req(OP_GET, 32'h0, 2'd2, 4'hF, 32'h0, 8'd99);
            #1;
            if (tl_o.a_ready) accepted++;
        end
        check("bp_accepted", 32'(accepted), 32'd3);
        check("bp_a_ready_full", 32'(tl_o.a_ready), 32'd0);
        @(negedge clk);
        tl_i.a_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_stall%0d_valid", k), 32'(tl_o.d_valid), 32'd1);
            check($sformatf("bp_stall%0d_source", k), 32'(tl_o.d_source), 32'd21);
            check($sformatf("bp_stall%0d_data", k), tl_o.d_data, bp_data[0]);
            @(negedge clk);
        end
        tl_i.d_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_drain%0d_valid", k), 32'(tl_o.d_valid), 32'd1);
            check($sformatf("bp_drain%0d_source", k), 32'(tl_o.d_source), 32'(21 + k));
            check($sformatf("bp_drain%0d_data", k), tl_o.d_data, bp_data[k]);
            @(negedge clk);
        end
        #1;
        check("bp_drained", 32'(tl_o.d_valid), 32'd0);

        // Streaming: one request and one response per cycle, FIFO pointers wrap.
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c < 12)
                set_req(OP_GET, (c % 2 == 0) ? 32'h10 : 32'h4, 2'd2, 4'hF, 32'h0, 8'(40 + c));
            else
                tl_i.a_valid = 1'b0;
            #1;
            if (c < 12) check($sformatf("st%0d_a_ready", c), 32'(tl_o.a_ready), 32'd1);
            if (c >= 2) begin
                check($sformatf("st%0d_d_valid", c), 32'(tl_o.d_valid), 32'd1);
                check($sformatf("st%0d_source", c), 32'(tl_o.d_source), 32'(40 + c - 2));
                check($sformatf("st%0d_data", c), tl_o.d_data, st_data[(c - 2) % 2]);
            end else begin
                check($sformatf("st%0d_d_valid", c), 32'(tl_o.d_valid), 32'd0);
            end
        end

        // Reset with two responses buffered drops them.
        @(negedge clk);
        tl_i.d_ready = 1'b0;
        set_req(OP_GET, 32'h10, 2'd2, 4'hF, 32'h0, 8'd60);
        @(negedge clk);
        set_req(OP_GET, 32'h4, 2'd2, 4'hF, 32'h0, 8'd61);
        @(negedge clk);
        tl_i.a_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rr_buffered_valid", 32'(tl_o.d_valid), 32'd1);
        check("rr_buffered_source", 32'(tl_o.d_source), 32'd60);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("rr_in_rst_d_valid", 32'(tl_o.d_valid), 32'd0);
        check("rr_in_rst_a_ready", 32'(tl_o.a_ready), 32'd0);
        @(negedge clk);
        rst_i        = 1'b0;
        tl_i.d_ready = 1'b1;
        #1;
        check("rr_release_a_ready", 32'(tl_o.a_ready), 32'd1);
        check("rr_release_d_valid", 32'(tl_o.d_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rr_after%0d_d_valid", k), 32'(tl_o.d_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlul_sram_responder.md
TLUL_SRAM_RESPONDER -- requirements
Module: tlul_sram_responder

Interface
REQ-001 The block SHALL expose parameter SRAM_AW, default 14, meaning the SRAM word-address width (64 KiB).
REQ-002 The block SHALL expose parameter RSP_DEPTH, default 3, meaning the number of response-buffer entries; the legal minimum is 2.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- tl_i  in  tlul_pkg::tl_h2d_t  TL-UL A channel and d_ready from the crossbar
- tl_o  out  tlul_pkg::tl_d2h_t  TL-UL D channel and a_ready to the crossbar
- sram_req_o  out  1  SRAM access strobe
- sram_we_o  out  1  write enable
- sram_addr_o  out  SRAM_AW  word address, equal to a_address[SRAM_AW+1:2]
- sram_wdata_o  out  32  write data
- sram_wmask_o  out  32  bit mask, each a_mask bit replicated ×8
- sram_rdata_i  in  32  read data, valid exactly 1 cycle after sram_req_o

Function
REQ-005 A-channel accept: a_fire = a_valid && a_ready.
REQ-006 a_ready SHALL be 1 iff (fifo_count + pend_valid) < RSP_DEPTH and rst_i = 0.
- a_ready SHALL NOT depend combinationally on d_ready.
REQ-007 Address bits above SRAM_AW+1 SHALL be ignored; the crossbar performs decode.
REQ-008 A request SHALL be flagged as an error if any of the following holds:
- opcode is not Get, PutFullData or PutPartialData;
- a_size > 2;
- the address is misaligned to a_size;
- PutFullData a_mask differs from the lane mask implied by a_size and address[1:0];
- a Put has a_mask = 0.
REQ-009 On a non-error a_fire, sram_req_o SHALL be 1 in the same cycle (combinational from A), with sram_we_o = 1 for Put and 0 for Get.
REQ-010 An error request SHALL never assert sram_req_o.
REQ-011 On a_fire, the pend stage SHALL capture {d_opcode, a_size, a_source, error}; d_opcode is AccessAckData for Get and AccessAck otherwise.
REQ-012 In the cycle after capture, the pend entry SHALL be pushed into the response FIFO.
- data = sram_rdata_i for a non-error Get; otherwise data = 0.
REQ-013 Fixed latency: A fire in cycle N gives the earliest d_valid in cycle N+2.
- Sustained throughput SHALL be 1 request/cycle with RSP_DEPTH ≥ 3 while d_ready = 1.
REQ-014 d_valid SHALL equal FIFO non-empty, and the D fields SHALL come from the FIFO head.
- d_param = 0, d_sink = 0, d_user = default, d_error = entry error.
REQ-015 The FIFO SHALL pop on d_valid && d_ready.
- A simultaneous push and pop SHALL leave the count unchanged.
- Pointers SHALL wrap modulo RSP_DEPTH.
REQ-016 Responses SHALL be returned strictly in acceptance order, errors included.
REQ-017 D fields SHALL be held stable while d_valid = 1 and d_ready = 0.

Reset
REQ-018 While rst_i = 1, all outputs SHALL be 0 (a_ready = 0, d_valid = 0, sram_req_o = 0), pend_valid SHALL be cleared and the FIFO pointers and count SHALL be cleared.
REQ-019 A reset asserted mid-transaction SHALL drop all in-flight responses without emitting D beats.
- a_ready SHALL return to 1 in the first cycle after rst_i deasserts.

Structure
REQ-020 The response-entry struct, the lane-mask function and the error-check function SHALL reside in the shared package tlul_sram_pkg, which imports tlul_pkg.
REQ-021 The response FIFO SHALL be a separate sub-module, tlul_rsp_fifo, parameterised by depth and entry type.
- It SHALL provide count and full/empty outputs.
REQ-022 No other sub-modules SHALL be used.

Verification
REQ-023 Get 0x0000_0010, size 2, source 5, with SRAM word 4 = 0xDEAD_BEEF:
- sram_addr_o = 4 at cycle N;
- d_valid at N+2 with d_data 0xDEAD_BEEF, AccessAckData, d_source 5, d_error 0.
REQ-024 PutPartialData at address 0x6, size 1, mask 0xC, data 0xABCD_0000:
- sram_wmask_o = 0xFFFF_0000, sram_we_o = 1;
- AccessAck response with d_error 0.
REQ-025 Get with size 2 at address 0x2, and PutFullData with mask 0x7 and size 2:
- no sram_req_o for either;
- each returns d_error 1 with d_data 0.
REQ-026 Back-to-back Gets with d_ready held at 0:
- exactly 3 accepted, then a_ready = 0;
- after raising d_ready, responses return in order with stable fields while stalled.
REQ-027 Continuous Gets with d_ready = 1:
- one response per cycle after a 2-cycle fill;
- push and pop in the same cycle;
- FIFO wrap exercised over ≥ 10 requests.
REQ-028 Assert rst_i with 2 responses buffered:
- no further d_valid;
- a_ready = 1 in the cycle after release.
